// File: rtl/p_hardisc.sv
// Shared core package: MDU operation encoding and small op-decode helpers.
package p_hardisc;

    // MDU operations in RISC-V M-extension funct3 order.
    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_t;

    // True for the four division-family operations.
    function automatic logic mdu_is_div(input mdu_op_t op);
        logic r;
        case (op)
            MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU: r = 1'b1;
            default:                              r = 1'b0;
        endcase
        return r;
    endfunction

    // True for the remainder operations.
    function automatic logic mdu_is_rem(input mdu_op_t op);
        logic r;
        case (op)
            MDU_REM, MDU_REMU: r = 1'b1;
            default:           r = 1'b0;
        endcase
        return r;
    endfunction

    // rs1 is interpreted as signed.
    function automatic logic mdu_op1_signed(input mdu_op_t op);
        logic r;
        case (op)
            MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM: r = 1'b1;
            default:                                r = 1'b0;
        endcase
        return r;
    endfunction

    // rs2 is interpreted as signed.
    function automatic logic mdu_op2_signed(input mdu_op_t op);
        logic r;
        case (op)
            MDU_MULH, MDU_DIV, MDU_REM: r = 1'b1;
            default:                    r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ex_mdu_seq_step.sv
// One radix step of the sequential MDU: R unsigned shift-add (multiply,
// LSB first) or restoring-subtract (divide, MSB first) iterations.
// Multiply: {acc,lo} holds {partial high, multiplier/low product}.
// Divide:   acc holds the partial remainder, lo the dividend/quotient.
module mdu_step #(
    parameter int W = 32,
    parameter int R = 1
) (
    input  logic         is_div_i,
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] lo_i,
    input  logic [W-1:0] mcand_i,
    output logic [W-1:0] acc_o,
    output logic [W-1:0] lo_o
);

    logic [W-1:0] acc_v;
    logic [W-1:0] lo_v;
    logic [W:0]   tmp_v;

    // Unrolled chain of R iterations on the working registers.
    always_comb begin
        acc_v = acc_i;
        lo_v  = lo_i;
        tmp_v = {(W+1){1'b0}};
        for (int i = 0; i < R; i++) begin
            if (is_div_i) begin
                // Shift the next dividend bit into the remainder, try subtract.
                tmp_v = {acc_v, lo_v[W-1]};
                lo_v  = {lo_v[W-2:0], 1'b0};
                if (tmp_v >= {1'b0, mcand_i}) begin
                    tmp_v   = tmp_v - {1'b0, mcand_i};
                    lo_v[0] = 1'b1;
                end else begin
                    lo_v[0] = 1'b0;
                end
                acc_v = tmp_v[W-1:0];
            end else begin
                // Add multiplicand when the current multiplier bit is set,
                // then shift the whole {carry,acc,lo} right by one.
                if (lo_v[0]) begin
                    tmp_v = {1'b0, acc_v} + {1'b0, mcand_i};
                end else begin
                    tmp_v = {1'b0, acc_v};
                end
                lo_v  = {tmp_v[0], lo_v[W-1:1]};
                acc_v = tmp_v[W:1];
            end
        end
        acc_o = acc_v;
        lo_o  = lo_v;
    end

endmodule

// File: rtl/ex_mdu_seq.sv
// Sequential EX-stage multiply/divide unit. Operands are reduced to
// magnitudes on capture, processed by an unsigned radix-R datapath for
// W/R cycles, and sign-corrected / half-selected in a single FIX cycle.
module ex_mdu_seq
    import p_hardisc::*;
#(
    parameter int W = 32,
    parameter int R = 1
) (
    input  logic         s_clk_i,
    input  logic         s_rst_i,
    input  logic         s_start_i,
    input  logic [2:0]   s_op_i,
    input  logic [W-1:0] s_operand1_i,
    input  logic [W-1:0] s_operand2_i,
    input  logic         s_stall_i,
    input  logic         s_flush_i,
    output logic         s_busy_o,
    output logic         s_finished_o,
    output logic [W-1:0] s_result_o
);

    localparam int STEPS = W / R;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [CW-1:0]  CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]  CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  CNT_LAST  = CW'(STEPS - 1);
    localparam logic [W-1:0]   ZERO_W    = {W{1'b0}};
    localparam logic [W-1:0]   ONE_W     = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]   ONES_W    = {W{1'b1}};
    localparam logic [W-1:0]   MIN_W     = {1'b1, {(W-1){1'b0}}};
    localparam logic [2*W-1:0] ONE_2W    = {{(2*W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    mdu_op_t         op_q;
    logic [W-1:0]    acc_q;
    logic [W-1:0]    lo_q;
    logic [W-1:0]    mcand_q;
    logic            neg_q;
    logic            rneg_q;
    logic            busy_q;
    logic            fin_q;
    logic [W-1:0]    res_q;

    mdu_op_t         op_s;
    logic            is_div_s;
    logic [W:0]      ext1_s;
    logic [W:0]      ext2_s;
    logic [W-1:0]    mag1_s;
    logic [W-1:0]    mag2_s;
    logic            special_s;
    logic [W-1:0]    special_res_s;

    logic [W-1:0]    step_acc_d;
    logic [W-1:0]    step_lo_d;
    logic [2*W-1:0]  prod_s;
    logic [2*W-1:0]  prod_fix_s;
    logic [W-1:0]    quo_fix_s;
    logic [W-1:0]    rem_fix_s;
    logic [W-1:0]    fix_res_d;

    // Decode the incoming op: extend operands to W+1 bits by signedness,
    // take magnitudes, and detect zero-divisor / signed-overflow shortcuts.
    always_comb begin
        op_s     = mdu_op_t'(s_op_i);
        is_div_s = mdu_is_div(op_s);
        ext1_s   = {mdu_op1_signed(op_s) & s_operand1_i[W-1], s_operand1_i};
        ext2_s   = {mdu_op2_signed(op_s) & s_operand2_i[W-1], s_operand2_i};
        if (ext1_s[W]) begin
            mag1_s = ~ext1_s[W-1:0] + ONE_W;
        end else begin
            mag1_s = ext1_s[W-1:0];
        end
        if (ext2_s[W]) begin
            mag2_s = ~ext2_s[W-1:0] + ONE_W;
        end else begin
            mag2_s = ext2_s[W-1:0];
        end
        special_s     = 1'b0;
        special_res_s = ZERO_W;
        if (is_div_s && (s_operand2_i == ZERO_W)) begin
            special_s     = 1'b1;
            special_res_s = mdu_is_rem(op_s) ? s_operand1_i : ONES_W;
        end else if (is_div_s && mdu_op1_signed(op_s) &&
                     (s_operand1_i == MIN_W) && (s_operand2_i == ONES_W)) begin
            special_s     = 1'b1;
            special_res_s = mdu_is_rem(op_s) ? ZERO_W : s_operand1_i;
        end else begin
            special_s     = 1'b0;
            special_res_s = ZERO_W;
        end
    end

    mdu_step #(
        .W (W),
        .R (R)
    ) u_step (
        .is_div_i (mdu_is_div(op_q)),
        .acc_i    (acc_q),
        .lo_i     (lo_q),
        .mcand_i  (mcand_q),
        .acc_o    (step_acc_d),
        .lo_o     (step_lo_d)
    );

    // FIX-cycle result: sign-correct, then pick product half or quotient/remainder.
    always_comb begin
        prod_s = {acc_q, lo_q};
        if (neg_q) begin
            prod_fix_s = ~prod_s + ONE_2W;
            quo_fix_s  = ~lo_q + ONE_W;
        end else begin
            prod_fix_s = prod_s;
            quo_fix_s  = lo_q;
        end
        if (rneg_q) begin
            rem_fix_s = ~acc_q + ONE_W;
        end else begin
            rem_fix_s = acc_q;
        end
        case (op_q)
            MDU_MUL:                         fix_res_d = prod_fix_s[W-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_res_d = prod_fix_s[2*W-1:W];
            MDU_DIV, MDU_DIVU:               fix_res_d = quo_fix_s;
            MDU_REM, MDU_REMU:               fix_res_d = rem_fix_s;
            default:                         fix_res_d = ZERO_W;
        endcase
    end

    // Control FSM with registered busy/finished/result outputs and datapath state.
    always_ff @(posedge s_clk_i) begin
        if (s_rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            op_q    <= MDU_MUL;
            acc_q   <= ZERO_W;
            lo_q    <= ZERO_W;
            mcand_q <= ZERO_W;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            res_q   <= ZERO_W;
        end else if (s_flush_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            res_q   <= ZERO_W;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s_start_i) begin
                        op_q    <= op_s;
                        acc_q   <= ZERO_W;
                        lo_q    <= is_div_s ? mag1_s : mag2_s;
                        mcand_q <= is_div_s ? mag2_s : mag1_s;
                        neg_q   <= ext1_s[W] ^ ext2_s[W];
                        rneg_q  <= ext1_s[W];
                        cnt_q   <= CNT_ZERO;
                        busy_q  <= 1'b1;
                        if (special_s) begin
                            state_q <= ST_DONE;
                            fin_q   <= 1'b1;
                            res_q   <= special_res_s;
                        end else begin
                            state_q <= ST_CALC;
                            fin_q   <= 1'b0;
                            res_q   <= ZERO_W;
                        end
                    end else begin
                        busy_q <= 1'b0;
                        fin_q  <= 1'b0;
                        res_q  <= ZERO_W;
                    end
                end
                ST_CALC: begin
                    acc_q <= step_acc_d;
                    lo_q  <= step_lo_d;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= CNT_ZERO;
                        state_q <= ST_FIX;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_FIX: begin
                    res_q   <= fix_res_d;
                    fin_q   <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    // Result stays put while the MA stage stalls us.
                    if (!s_stall_i) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        fin_q   <= 1'b0;
                        res_q   <= ZERO_W;
                    end else begin
                        fin_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= CNT_ZERO;
                    busy_q  <= 1'b0;
                    fin_q   <= 1'b0;
                    res_q   <= ZERO_W;
                end
            endcase
        end
    end

    assign s_busy_o     = busy_q;
    assign s_finished_o = fin_q;
    assign s_result_o   = res_q;

endmodule

// File: doc/ex_mdu_seq.md
EX_MDU_SEQ -- requirements
Module: ex_mdu_seq

Interface
REQ-001 SHALL have parameter W, default 32, meaning operand/result width; legal values are even and >= 8.
REQ-002 SHALL have parameter R, default 1, meaning result bits per CALC cycle; legal values are 1, 2 and 4, and R divides W.
REQ-003 SHALL have port s_clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port s_rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port s_start_i, input, 1 bit: an EX-stage MDU instruction is present.
REQ-006 SHALL have port s_op_i, input, 3 bits: mdu_op_t, in RISC-V M funct3 order MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-007 SHALL have ports s_operand1_i and s_operand2_i, input, W bits each: rs1/rs2 values after forwarding.
REQ-008 SHALL have port s_stall_i, input, 1 bit: the EX stage is stalled by the MA stage.
REQ-009 SHALL have port s_flush_i, input, 1 bit: abort the current operation.
REQ-010 SHALL have port s_busy_o, output, 1 bit: state is not IDLE.
REQ-011 SHALL have port s_finished_o, output, 1 bit: s_result_o is valid.
REQ-012 SHALL have port s_result_o, output, W bits: the operation result.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX and DONE.
REQ-014 SHALL, in IDLE with s_start_i=1, capture the operands and op, and enter CALC, or DONE for a special case (REQ-019/020).
REQ-015 SHALL spend exactly W/R cycles in CALC, producing R quotient or product bits per cycle with an internal step counter of width clog2(W/R).
REQ-016 SHALL spend one cycle in FIX: sign correction, then selection of the high or low product half, or of the quotient or remainder.
REQ-017 SHALL make normal latency from start-accept cycle t to s_finished_o=1 equal to W/R+2 cycles (W=32, R=1: 34; R=4: 10).
REQ-018 SHALL hold DONE, with s_finished_o=1 and a stable s_result_o, while s_stall_i=1, and go to IDLE on the first cycle with s_stall_i=0.
REQ-019 SHALL treat a zero divisor as a special case: finished at t+1; DIV/DIVU result all-ones; REM/REMU result = dividend.
REQ-020 SHALL treat signed overflow (dividend = most-negative, divisor = -1) as a special case: finished at t+1; DIV result = dividend; REM result = 0.
REQ-021 SHALL ignore s_start_i in CALC, FIX and DONE, with no recapture of operands.
REQ-022 SHALL take s_flush_i=1 in any state to IDLE the next cycle, with s_finished_o=0 and no result delivered; flush has priority over start in the same cycle.
REQ-023 SHALL hold s_finished_o at 0 outside DONE.
REQ-024 SHALL let s_stall_i have no effect on CALC or FIX progress.
REQ-025 SHALL compute MULH, MULHSU and MULHU on operands sign-extended to W+1 bits by op, so that one shared datapath serves all three.
REQ-026 SHALL drive s_result_o to 0 in IDLE.

Reset
REQ-027 SHALL, with s_rst_i=1 at a clock edge, force state IDLE, step counter 0, s_busy_o=0, s_finished_o=0 and s_result_o=0, overriding start and flush.
REQ-028 SHALL, when reset occurs mid-CALC, discard the operation, and SHALL accept a fresh start on the first cycle after s_rst_i is released.

Structure
REQ-029 SHALL take mdu_op_t and the MDU_* op constants from the shared p_hardisc package; state encoding stays local.
REQ-030 SHALL place one radix step (R shift-add or restoring-subtract iterations, purely combinational) in sub-module mdu_step, instantiated once.
REQ-031 SHALL carry no replication internally; the EX stage instantiates one copy per PROT_2REP replica and compares s_finished_o across replicas.

Verification
REQ-032 SHALL cover: W=32, R=1, MUL 7 x -3, start at t -> s_finished_o=1 at t+34, s_result_o=0xFFFFFFEB.
REQ-033 SHALL cover: W=32, R=4, MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE at t+10.
REQ-034 SHALL cover: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at t+1; REM of the same operands -> 0; DIVU 5 / 0 -> 0xFFFFFFFF at t+1.
REQ-035 SHALL cover: REM -7 / 2 -> 0xFFFFFFFF; s_stall_i=1 for 5 cycles in DONE -> result stable for all 5; s_stall_i=0 -> IDLE the next cycle.
REQ-036 SHALL cover: flush in CALC cycle 10 -> IDLE next cycle, s_finished_o never asserted; a new DIVU 100/7 started 2 cycles later -> 14.
REQ-037 SHALL cover: s_rst_i asserted mid-CALC together with s_start_i -> IDLE with all outputs 0; s_start_i the cycle after release is accepted.
